// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave for the core's
// load/store port. Requests are security-checked (alignment, range and
// protected window) before they are allowed to touch the word array.
module dmem_responder #(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] SEC_BASE  = 32'h0000_0300,
   parameter logic [31:0] SEC_LIMIT = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   input  logic        req_priv,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [7:0]  err_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned BE_W    = 4;
   localparam int unsigned CNT_W   = 8;
   localparam logic [31:0] ADDR_END = 32'(DEPTH * 4);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;

   logic              r_we;
   logic [31:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic              r_priv;

   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic [CNT_W-1:0]  r_err_count;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_req_hs;
   logic              w_rsp_hs;
   logic              w_err;
   logic              w_mem_wr;
   logic [ADDR_W-1:0] w_word_idx;
   logic [DATA_W-1:0] w_rd_word;

   assign w_req_hs   = (r_state == ST_IDLE) & req_valid & r_req_ready;
   assign w_rsp_hs   = (r_state == ST_RESP) & r_rsp_valid & rsp_ready;
   assign w_word_idx = r_addr[ADDR_W+1:2];
   assign w_rd_word  = r_mem[w_word_idx];

   // Refusal: misaligned, beyond the array (no aliasing), or unprivileged
   // access inside the protected window.
   assign w_err = (r_addr[1:0] != 2'b00)
                | (r_addr >= ADDR_END)
                | (~r_priv & (r_addr >= SEC_BASE) & (r_addr < SEC_LIMIT));

   // A store commits only at the ACCESS closing edge; reset forces IDLE first.
   assign w_mem_wr = (r_state == ST_ACCESS) & r_we & ~w_err;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_req_hs) begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_next_state = ST_RESP;
         end
         ST_RESP: begin
            if (w_rsp_hs) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Capture the request fields at the request handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_priv  <= 1'b0;
      end else if (w_req_hs) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_be    <= req_be;
         r_priv  <= req_priv;
      end
   end

   // Registered handshake flags, response payload and refusal counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_req_ready <= (w_next_state == ST_IDLE);
         r_rsp_valid <= (w_next_state == ST_RESP);
         if (r_state == ST_ACCESS) begin
            r_rsp_err <= w_err;
            if (!w_err && !r_we) begin
               r_rsp_rdata <= w_rd_word;
            end else begin
               r_rsp_rdata <= '0;
            end
            if (w_err && (r_err_count != CNT_MAX)) begin
               r_err_count <= r_err_count + CNT_W'(1);
            end
         end else if (w_rsp_hs) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
         end
      end
   end

   // Byte-lane writes into the word array; contents survive reset
   always_ff @(posedge clk) begin
      if (w_mem_wr) begin
         for (int i = 0; i < int'(BE_W); i++) begin
            if (r_be[i]) begin
               r_mem[w_word_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign err_count = r_err_count;

endmodule
